// File: rtl/vending_machine_multi_if.sv
// Signal bundle between the coin acceptor/dispenser side (master) and the vending controller
// (slave).
interface vending_machine_multi_if #(
    parameter int unsigned NUM_PRODUCTS = 4,
    parameter int unsigned CREDIT_W     = 8
);
    localparam int unsigned SelW = $clog2(NUM_PRODUCTS);

    logic [1:0]                       coin_in;
    logic                             sel_valid;
    logic [SelW-1:0]                  sel_id;
    logic                             cancel;
    logic [NUM_PRODUCTS*CREDIT_W-1:0] price_table;
    logic [NUM_PRODUCTS-1:0]          stock_empty;
    logic                             vend_valid;
    logic [SelW-1:0]                  vend_id;
    logic                             vend_ready;
    logic                             change_coin;
    logic                             coin_reject;
    logic                             sel_error;
    logic [CREDIT_W-1:0]              credit;
    logic [1:0]                       state;

    modport master (
        output coin_in, sel_valid, sel_id, cancel, price_table, stock_empty, vend_ready,
        input  vend_valid, vend_id, change_coin, coin_reject, sel_error, credit, state
    );

    modport slave (
        input  coin_in, sel_valid, sel_id, cancel, price_table, stock_empty, vend_ready,
        output vend_valid, vend_id, change_coin, coin_reject, sel_error, credit, state
    );
endinterface

// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: coin credit accumulation, priced selection, valid/ready
// dispense and unit-coin change return.
module vending_machine_multi #(
    parameter int unsigned NUM_PRODUCTS = 4,
    parameter int unsigned CREDIT_W     = 8,
    parameter int unsigned COIN_A       = 5,
    parameter int unsigned COIN_B       = 10,
    parameter int unsigned COIN_C       = 20,
    parameter int unsigned CHANGE_UNIT  = 5,
    parameter int unsigned MAX_CREDIT   = 50
) (
    input logic                    clk,
    input logic                    rst,
    vending_machine_multi_if.slave bus
);
    localparam int unsigned SelW = $clog2(NUM_PRODUCTS);
    localparam int unsigned SumW = CREDIT_W + 1;

    if (MAX_CREDIT > (2 ** CREDIT_W) - 1) begin : g_max_credit_check
        $error("MAX_CREDIT does not fit in CREDIT_W");
    end
    if (NUM_PRODUCTS < 2) begin : g_num_products_check
        $error("NUM_PRODUCTS must be at least 2");
    end

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StCredit = 2'b01,
        StVend   = 2'b10,
        StChange = 2'b11
    } state_e;

    state_e              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [SelW-1:0]     vend_id_q;
    logic                vend_valid_q;
    logic                change_coin_q;
    logic                coin_reject_q;
    logic                sel_error_q;

    logic [SumW-1:0]     coin_val;
    logic [SumW-1:0]     credit_sum;
    logic                coin_present;
    logic                coin_fits;
    logic [CREDIT_W-1:0] price;
    logic                sel_in_range;
    logic                sold_out;
    logic                sel_ok;

    always_comb begin
        coin_val = '0;
        case (bus.coin_in)
            2'b01:   coin_val = SumW'(COIN_A);
            2'b10:   coin_val = SumW'(COIN_B);
            2'b11:   coin_val = SumW'(COIN_C);
            default: coin_val = '0;
        endcase
        coin_present = bus.coin_in != 2'b00;
        credit_sum   = {1'b0, credit_q} + coin_val;
        coin_fits    = coin_present && (credit_sum <= SumW'(MAX_CREDIT));
    end

    // Product lookup by loop so out-of-range ids (non power-of-two counts) never index past the
    // table.
    always_comb begin
        price        = '0;
        sel_in_range = 1'b0;
        sold_out     = 1'b0;
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            if (bus.sel_id == SelW'(i)) begin
                price        = bus.price_table[i*CREDIT_W +: CREDIT_W];
                sel_in_range = 1'b1;
                sold_out     = bus.stock_empty[i];
            end
        end
        sel_ok = sel_in_range && !sold_out && (credit_q >= price);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            credit_q      <= '0;
            vend_id_q     <= '0;
            vend_valid_q  <= 1'b0;
            change_coin_q <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_error_q   <= 1'b0;
        end else begin
            coin_reject_q <= 1'b0;
            sel_error_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    sel_error_q <= bus.sel_valid;
                    if (coin_fits) begin
                        credit_q <= credit_sum[CREDIT_W-1:0];
                        state_q  <= StCredit;
                    end else begin
                        coin_reject_q <= coin_present;
                    end
                end
                StCredit: begin
                    if (bus.cancel) begin
                        coin_reject_q <= coin_present;
                        if (credit_q == '0) begin
                            state_q <= StIdle;
                        end else begin
                            state_q       <= StChange;
                            change_coin_q <= 1'b1;
                        end
                    end else if (bus.sel_valid && sel_ok) begin
                        coin_reject_q <= coin_present;
                        credit_q      <= credit_q - price;
                        vend_id_q     <= bus.sel_id;
                        vend_valid_q  <= 1'b1;
                        state_q       <= StVend;
                    end else begin
                        // A refused selection does not block the coin of the same cycle.
                        sel_error_q <= bus.sel_valid;
                        if (coin_fits) begin
                            credit_q <= credit_sum[CREDIT_W-1:0];
                        end else begin
                            coin_reject_q <= coin_present;
                        end
                    end
                end
                StVend: begin
                    coin_reject_q <= coin_present;
                    sel_error_q   <= bus.sel_valid;
                    if (bus.vend_ready) begin
                        vend_valid_q <= 1'b0;
                        if (credit_q == '0) begin
                            state_q <= StIdle;
                        end else begin
                            state_q       <= StChange;
                            change_coin_q <= 1'b1;
                        end
                    end
                end
                StChange: begin
                    coin_reject_q <= coin_present;
                    sel_error_q   <= bus.sel_valid;
                    if (credit_q <= CREDIT_W'(CHANGE_UNIT)) begin
                        credit_q      <= '0;
                        change_coin_q <= 1'b0;
                        state_q       <= StIdle;
                    end else begin
                        credit_q <= credit_q - CREDIT_W'(CHANGE_UNIT);
                    end
                end
            endcase
        end
    end

    assign bus.state       = state_q;
    assign bus.credit      = credit_q;
    assign bus.vend_id     = vend_id_q;
    assign bus.vend_valid  = vend_valid_q;
    assign bus.change_coin = change_coin_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.sel_error   = sel_error_q;
endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed scenarios plus randomized traffic checked against a cycle-level behavioural model.
module tb_vending_machine_multi;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    vending_machine_multi_if #(.NUM_PRODUCTS(4), .CREDIT_W(8)) bus ();

    vending_machine_multi #(
        .NUM_PRODUCTS(4), .CREDIT_W(8), .COIN_A(5), .COIN_B(10), .COIN_C(20),
        .CHANGE_UNIT(5), .MAX_CREDIT(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Reference model: phase uses the published state codes, money in plain integers.
    int m_phase, m_credit, m_vend_id, m_rej, m_err;
    int m_price[4];
    bit m_stock_empty[4];
    int coin_value[4] = '{0, 5, 10, 20};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.coin_in    = 2'b00;
        bus.sel_valid  = 1'b0;
        bus.sel_id     = 2'd0;
        bus.cancel     = 1'b0;
        bus.vend_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic coin(input logic [1:0] c);
        bus.coin_in = c;
        tick();
        bus.coin_in = 2'b00;
    endtask

    task automatic sel(input logic [1:0] id);
        bus.sel_valid = 1'b1;
        bus.sel_id    = id;
        tick();
        bus.sel_valid = 1'b0;
    endtask

    task automatic model_step(input bit r, input int c, input bit s, input int id,
                              input bit cn, input bit rdy);
        int v;
        v = coin_value[c];
        m_rej = 0;
        m_err = 0;
        if (r) begin
            m_phase = 0; m_credit = 0; m_vend_id = 0;
            return;
        end
        case (m_phase)
            0: begin
                m_err = s;
                if (c != 0 && m_credit + v <= 50) begin
                    m_credit += v; m_phase = 1;
                end else m_rej = (c != 0);
            end
            1: begin
                if (cn) begin
                    m_rej = (c != 0);
                    m_phase = (m_credit == 0) ? 0 : 3;
                end else if (s && !m_stock_empty[id] && m_credit >= m_price[id]) begin
                    m_rej = (c != 0);
                    m_credit -= m_price[id]; m_vend_id = id; m_phase = 2;
                end else begin
                    m_err = s;
                    if (c != 0 && m_credit + v <= 50) m_credit += v;
                    else m_rej = (c != 0);
                end
            end
            2: begin
                m_rej = (c != 0); m_err = s;
                if (rdy) m_phase = (m_credit == 0) ? 0 : 3;
            end
            default: begin
                m_rej = (c != 0); m_err = s;
                m_credit -= 5;
                if (m_credit <= 0) begin m_credit = 0; m_phase = 0; end
            end
        endcase
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_checks++;
        if (bus.state !== 2'b00) $display("FAIL reset_state: got %0d want 0", bus.state);
        else n_pass++;
        n_checks++;
        if (bus.credit !== 8'd0) $display("FAIL reset_credit: got %0d want 0", bus.credit);
        else n_pass++;
        n_checks++;
        if ({bus.vend_valid, bus.change_coin, bus.coin_reject, bus.sel_error, bus.vend_id} !== 6'd0)
            $display("FAIL reset_outputs: vv=%b cc=%b cr=%b se=%b id=%0d want all 0",
                     bus.vend_valid, bus.change_coin, bus.coin_reject, bus.sel_error, bus.vend_id);
        else n_pass++;
    endtask

    task automatic test_purchase();
        do_reset();
        coin(2'b01);
        n_checks++;
        if (bus.credit !== 8'd5 || bus.state !== 2'b01)
            $display("FAIL purchase_coin1: credit=%0d state=%0d want 5/1", bus.credit, bus.state);
        else n_pass++;
        coin(2'b10);
        n_checks++;
        if (bus.credit !== 8'd15) $display("FAIL purchase_coin2: got %0d want 15", bus.credit);
        else n_pass++;
        sel(2'd0);
        n_checks++;
        if (bus.vend_valid !== 1'b1 || bus.vend_id !== 2'd0 || bus.credit !== 8'd0
            || bus.state !== 2'b10)
            $display("FAIL purchase_vend: vv=%b id=%0d credit=%0d state=%0d want 1/0/0/2",
                     bus.vend_valid, bus.vend_id, bus.credit, bus.state);
        else n_pass++;
        bus.vend_ready = 1'b1;
        tick();
        bus.vend_ready = 1'b0;
        n_checks++;
        if (bus.state !== 2'b00 || bus.vend_valid !== 1'b0 || bus.change_coin !== 1'b0)
            $display("FAIL purchase_done: state=%0d vv=%b cc=%b want 0/0/0",
                     bus.state, bus.vend_valid, bus.change_coin);
        else n_pass++;
    endtask

    task automatic test_change();
        int pulses;
        do_reset();
        coin(2'b10);
        coin(2'b10);
        sel(2'd0);
        bus.vend_ready = 1'b1;
        tick();
        bus.vend_ready = 1'b0;
        n_checks++;
        if (bus.state !== 2'b11 || bus.change_coin !== 1'b1 || bus.credit !== 8'd5)
            $display("FAIL change_enter: state=%0d cc=%b credit=%0d want 3/1/5",
                     bus.state, bus.change_coin, bus.credit);
        else n_pass++;
        pulses = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.change_coin) pulses++;
            else break;
        end
        n_checks++;
        if (pulses !== 1 || bus.state !== 2'b00 || bus.credit !== 8'd0)
            $display("FAIL change_pulses: pulses=%0d state=%0d credit=%0d want 1/0/0",
                     pulses, bus.state, bus.credit);
        else n_pass++;
    endtask

    task automatic test_sel_error();
        do_reset();
        coin(2'b10);
        sel(2'd0);
        n_checks++;
        if (bus.sel_error !== 1'b1 || bus.state !== 2'b01 || bus.credit !== 8'd10)
            $display("FAIL selerr_price: se=%b state=%0d credit=%0d want 1/1/10",
                     bus.sel_error, bus.state, bus.credit);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.sel_error !== 1'b0) $display("FAIL selerr_pulse_width: got %b want 0", bus.sel_error);
        else n_pass++;
        bus.stock_empty = 4'b0010;
        coin(2'b10);
        sel(2'd1);
        n_checks++;
        if (bus.sel_error !== 1'b1 || bus.vend_valid !== 1'b0 || bus.credit !== 8'd20)
            $display("FAIL selerr_stock: se=%b vv=%b credit=%0d want 1/0/20",
                     bus.sel_error, bus.vend_valid, bus.credit);
        else n_pass++;
        bus.stock_empty = 4'b0000;
    endtask

    task automatic test_cancel();
        int pulses, exp_credit;
        do_reset();
        coin(2'b10);
        coin(2'b10);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        n_checks++;
        if (bus.state !== 2'b11 || bus.change_coin !== 1'b1 || bus.credit !== 8'd20)
            $display("FAIL cancel_enter: state=%0d cc=%b credit=%0d want 3/1/20",
                     bus.state, bus.change_coin, bus.credit);
        else n_pass++;
        pulses = 1;
        exp_credit = 20;
        for (int i = 0; i < 8 && bus.state != 2'b00; i++) begin
            bus.coin_in = (i == 0) ? 2'b01 : 2'b00;
            tick();
            bus.coin_in = 2'b00;
            exp_credit -= 5;
            n_checks++;
            if (bus.credit !== 8'(exp_credit))
                $display("FAIL cancel_credit: got %0d want %0d", bus.credit, exp_credit);
            else n_pass++;
            if (i == 0) begin
                n_checks++;
                if (bus.coin_reject !== 1'b1)
                    $display("FAIL cancel_coin_reject: got %b want 1", bus.coin_reject);
                else n_pass++;
            end
            if (bus.change_coin) pulses++;
        end
        n_checks++;
        if (pulses !== 4 || bus.state !== 2'b00)
            $display("FAIL cancel_pulses: pulses=%0d state=%0d want 4/0", pulses, bus.state);
        else n_pass++;
    endtask

    task automatic test_max_credit();
        do_reset();
        coin(2'b11);
        coin(2'b11);
        coin(2'b01);
        coin(2'b10);
        n_checks++;
        if (bus.coin_reject !== 1'b1 || bus.credit !== 8'd45)
            $display("FAIL max_over: cr=%b credit=%0d want 1/45", bus.coin_reject, bus.credit);
        else n_pass++;
        coin(2'b01);
        n_checks++;
        if (bus.coin_reject !== 1'b0 || bus.credit !== 8'd50)
            $display("FAIL max_fill: cr=%b credit=%0d want 0/50", bus.coin_reject, bus.credit);
        else n_pass++;
        coin(2'b01);
        n_checks++;
        if (bus.coin_reject !== 1'b1 || bus.credit !== 8'd50)
            $display("FAIL max_full: cr=%b credit=%0d want 1/50", bus.coin_reject, bus.credit);
        else n_pass++;
    endtask

    task automatic test_price_zero();
        do_reset();
        bus.price_table[31:24] = 8'd0;
        coin(2'b01);
        bus.coin_in = 2'b10;
        sel(2'd3);
        bus.coin_in = 2'b00;
        n_checks++;
        if (bus.state !== 2'b10 || bus.credit !== 8'd5 || bus.coin_reject !== 1'b1
            || bus.vend_id !== 2'd3)
            $display("FAIL zero_price: state=%0d credit=%0d cr=%b id=%0d want 2/5/1/3",
                     bus.state, bus.credit, bus.coin_reject, bus.vend_id);
        else n_pass++;
        bus.vend_ready = 1'b1;
        tick();
        bus.vend_ready = 1'b0;
        tick();
        n_checks++;
        if (bus.state !== 2'b00 || bus.credit !== 8'd0)
            $display("FAIL zero_price_refund: state=%0d credit=%0d want 0/0", bus.state, bus.credit);
        else n_pass++;
        bus.price_table[31:24] = 8'd30;
    endtask

    task automatic test_reset_mid();
        int pulses;
        do_reset();
        coin(2'b11);
        coin(2'b10);
        sel(2'd2);
        tick();
        n_checks++;
        if (bus.vend_valid !== 1'b1 || bus.vend_id !== 2'd2)
            $display("FAIL rstmid_hold: vv=%b id=%0d want 1/2", bus.vend_valid, bus.vend_id);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (bus.state !== 2'b00 || bus.credit !== 8'd0 || bus.vend_valid !== 1'b0
            || bus.vend_id !== 2'd0)
            $display("FAIL rstmid_vend: state=%0d credit=%0d vv=%b id=%0d want 0/0/0/0",
                     bus.state, bus.credit, bus.vend_valid, bus.vend_id);
        else n_pass++;
        coin(2'b11);
        coin(2'b11);
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.change_coin) pulses++;
            tick();
        end
        n_checks++;
        if (pulses !== 0 || bus.state !== 2'b00 || bus.credit !== 8'd0)
            $display("FAIL rstmid_change: pulses=%0d state=%0d credit=%0d want 0/0/0",
                     pulses, bus.state, bus.credit);
        else n_pass++;
    endtask

    task automatic test_random();
        bit r, s, cn, rdy;
        int c, id;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            m_price[i] = 5 * $urandom_range(0, 8);
            m_stock_empty[i] = ($urandom_range(0, 3) == 0);
            bus.price_table[i*8 +: 8] = 8'(m_price[i]);
            bus.stock_empty[i] = m_stock_empty[i];
        end
        m_phase = 0; m_credit = 0; m_vend_id = 0;
        for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(0, 99) == 0);
            c   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            s   = ($urandom_range(0, 5) == 0);
            id  = $urandom_range(0, 3);
            cn  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            rst = r;
            bus.coin_in = 2'(c); bus.sel_valid = s; bus.sel_id = 2'(id);
            bus.cancel = cn; bus.vend_ready = rdy;
            model_step(r, c, s, id, cn, rdy);
            tick();
            n_checks++;
            if (bus.state !== 2'(m_phase) || bus.credit !== 8'(m_credit)
                || bus.vend_valid !== (m_phase == 2) || bus.change_coin !== (m_phase == 3)
                || bus.vend_id !== 2'(m_vend_id) || bus.coin_reject !== 1'(m_rej)
                || bus.sel_error !== 1'(m_err))
                $display("FAIL random_cycle%0d: st=%0d cr=%0d vv=%b cc=%b id=%0d rj=%b se=%b want %0d/%0d/%0d/%0d/%0d/%0d/%0d",
                         n, bus.state, bus.credit, bus.vend_valid, bus.change_coin, bus.vend_id,
                         bus.coin_reject, bus.sel_error, m_phase, m_credit, m_phase == 2,
                         m_phase == 3, m_vend_id, m_rej, m_err);
            else n_pass++;
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        bus.price_table = {8'd30, 8'd25, 8'd20, 8'd15};
        bus.stock_empty = 4'b0000;
        clear_inputs();
        test_reset();
        test_purchase();
        test_change();
        test_sel_error();
        test_cancel();
        test_max_credit();
        test_price_zero();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
